// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared op codes, FSM states and op-class helpers for the RV32M unit
package alu_muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;
  function automatic logic is_signed_a(op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic is_signed_b(op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
  function automatic logic is_div(op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction
  function automatic logic is_rem(op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction
endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response bundle between EX stage and the mul/div unit
interface alu_muldiv_if
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic start, flush, busy, done;
  op_t op;
  logic [WIDTH-1:0] a, b, result;
  modport master (output start, flush, op, a, b, input busy, done, result);
  modport slave (input start, flush, op, a, b, output busy, done, result);
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: unsigned one-bit-per-step shift-add multiply / restoring divide datapath
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);
  logic [WIDTH-1:0] acc, q, m;
  logic [WIDTH:0] sum, shl, diff;
  // next accumulator/shift-register values; the owner samples them on the final step
  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shl = {acc, q[WIDTH-1]};
    diff = shl - {1'b0, m};
    hi_n = div ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    lo_n = div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
  end
  // load operands on accept, advance one bit per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q <= '0;
      m <= '0;
    end else if (load) begin
      acc <= '0;
      q <= x;
      m <= y;
    end else if (step) begin
      acc <= hi_n;
      q <= lo_n;
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit with sign fix-up and special-case bypass
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state;
  op_t op_r;
  logic neg_r, busy_q, done_q, sa, sb, special;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] res_q, mag_a, mag_b, spec_res, hi_n, lo_n, div_v, res_n;
  logic [2*WIDTH-1:0] prod;
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (state == IDLE && bus.start && !bus.flush),
    .step (state == RUN),
    .div  (is_div(op_r)),
    .x    (mag_a),
    .y    (mag_b),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );
  // accept-time magnitudes and special-case detect, plus final sign fix-up of the core result
  always_comb begin
    sa = is_signed_a(bus.op) & bus.a[WIDTH-1];
    sb = is_signed_b(bus.op) & bus.b[WIDTH-1];
    mag_a = sa ? -bus.a : bus.a;
    mag_b = sb ? -bus.b : bus.b;
    special = is_div(bus.op) & ((bus.b == '0) | (is_signed_b(bus.op) & bus.a == MIN & bus.b == '1));
    spec_res = bus.b == '0 ? (is_rem(bus.op) ? bus.a : '1) : (is_rem(bus.op) ? '0 : bus.a);
    prod = neg_r ? -{hi_n, lo_n} : {hi_n, lo_n};
    div_v = is_rem(op_r) ? hi_n : lo_n;
    res_n = is_div(op_r) ? (neg_r ? -div_v : div_v) :
            (op_r == OP_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  end
  // control FSM: flush beats start, result register only loads on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r <= OP_MUL;
      neg_r <= 1'b0;
      cnt <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_r <= bus.op;
          neg_r <= sa ^ (sb & ~is_rem(bus.op));
          cnt <= '0;
          busy_q <= 1'b1;
          done_q <= special;
          state <= special ? DONE : RUN;
          if (special) res_q <= spec_res;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            done_q <= 1'b1;
            res_q <= res_n;
          end
        end
        DONE: begin
          state <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.result = res_q;
endmodule
